// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader -- boot-time program loader.
// Receives a big-endian byte stream: a 4-byte word count N, then N 32-bit
// instruction words (written to instruction memory at addresses 0..N-1),
// then, when PROG_LOADER_CHECKSUM_EN is defined, a 4-byte XOR checksum.
// The processor is held in reset until the program has been loaded, and
// is held again if loading fails.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   in_data      program byte stream
//   in_valid     in_data valid
//   in_ready     loader accepts a byte (transfer when in_valid & in_ready)
//   reload       single-cycle restart request, honoured in RUN and ERR only
//   imem_we      instruction-memory write strobe (one cycle per word)
//   imem_addr    instruction-memory word address
//   imem_wdata   instruction word to write
//   cpu_reset    active-high processor reset
//   loaded_words number of words written since the last load start
//   err          load failed; processor held in reset
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (adds the CHK state and
// the XOR accumulator).
module prog_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   loaded_words,
  output logic              err
);

  localparam logic [31:0] DEPTH = 32'(2**ADDR_W);

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CHK  = 3'd2,
`endif
    ST_REL  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = ST_CHK;
`else
  localparam state_t POST_DATA = ST_REL;
`endif

  state_t            state_r;
  state_t            state_next_s;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       shift_r;      // first three bytes of the current field
  logic [ADDR_W:0]   count_r;      // N from the header (only valid when N <= DEPTH)
  logic [ADDR_W:0]   loaded_r;     // doubles as the next word index
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]       xor_r;
`endif

  logic              in_ready_s;
  logic              cpu_reset_s;
  logic              err_s;
  logic              xfer_s;
  logic              word_done_s;
  logic [31:0]       word_s;
  logic              last_word_s;
  logic              reload_go_s;

  assign xfer_s      = in_valid & in_ready_s;
  assign word_done_s = xfer_s & (byte_cnt_r == 2'd3);
  assign word_s      = {shift_r, in_data};
  assign last_word_s = ((loaded_r + {{ADDR_W{1'b0}}, 1'b1}) == count_r);
  assign reload_go_s = reload & ((state_r == ST_RUN) | (state_r == ST_ERR));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; the last word's transfer moves straight on so the
  // write strobe coincides with REL/CHK and no extra byte is accepted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (word_done_s) begin
          if (word_s > DEPTH) begin
            state_next_s = ST_ERR;
          end else if (word_s == 32'd0) begin
            state_next_s = POST_DATA;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (word_done_s && last_word_s) begin
          state_next_s = POST_DATA;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (word_done_s) begin
          if (word_s == xor_r) begin
            state_next_s = ST_REL;
          end else begin
            state_next_s = ST_ERR;
          end
        end else begin
          state_next_s = ST_CHK;
        end
      end
`endif
      ST_REL: begin
        state_next_s = ST_RUN;
      end
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_next_s = ST_HDR;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = ST_HDR;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready_s  = 1'b0;
    cpu_reset_s = 1'b1;
    err_s       = 1'b0;
    case (state_r)
      ST_HDR, ST_LOAD: begin
        in_ready_s = 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        in_ready_s = 1'b1;
      end
`endif
      ST_RUN: begin
        cpu_reset_s = 1'b0;
      end
      ST_ERR: begin
        err_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Byte assembly, word counting and the registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_r <= 2'd0;
      shift_r    <= 24'd0;
      count_r    <= {(ADDR_W+1){1'b0}};
      loaded_r   <= {(ADDR_W+1){1'b0}};
      we_r       <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_r      <= 32'd0;
`endif
    end else begin
      we_r <= 1'b0;
      if (reload_go_s) begin
        byte_cnt_r <= 2'd0;
        shift_r    <= 24'd0;
        count_r    <= {(ADDR_W+1){1'b0}};
        loaded_r   <= {(ADDR_W+1){1'b0}};
`ifdef PROG_LOADER_CHECKSUM_EN
        xor_r      <= 32'd0;
`endif
      end else if (xfer_s) begin
        shift_r    <= {shift_r[15:0], in_data};
        byte_cnt_r <= byte_cnt_r + 2'd1;
        if (word_done_s && (state_r == ST_HDR)) begin
          count_r <= word_s[ADDR_W:0];
        end else if (word_done_s && (state_r == ST_LOAD)) begin
          we_r     <= 1'b1;
          addr_r   <= loaded_r[ADDR_W-1:0];
          wdata_r  <= word_s;
          loaded_r <= loaded_r + {{ADDR_W{1'b0}}, 1'b1};
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_r    <= xor_r ^ word_s;
`endif
        end
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign cpu_reset    = cpu_reset_s;
  assign err          = err_s;
  assign imem_we      = we_r;
  assign imem_addr    = addr_r;
  assign imem_wdata   = wdata_r;
  assign loaded_words = loaded_r;

endmodule
